// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} booth_state_e;

    typedef enum logic [1:0] {OP_NOP, OP_ADD, OP_SUB} booth_op_e;

    // Counter must reach WIDTH; WIDTH+2 leaves headroom for the post-increment value.
    function automatic int booth_cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

    function automatic booth_op_e booth_decode(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_mul_vr_ctrl.sv
// Booth multiplier controller: FSM, step counter, handshakes, datapath enables.
// Handshake: a transfer occurs on a rising edge where valid && ready are both high.
module booth_mul_vr_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = booth_cnt_w(WIDTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         src_valid_i,
    input  logic         dest_ready_i,
    input  logic         zero_i,
    output logic         src_ready_o,
    output logic         dest_valid_o,
    output logic         load_o,
    output logic         step_o,
    output booth_state_e state_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    booth_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        src_ready_o  = 1'b0;
        dest_valid_o = 1'b0;
        load_o       = 1'b0;
        step_o       = 1'b0;
        case (state_q)
            IDLE: begin
                src_ready_o = 1'b1;
                if (src_valid_i) begin
                    load_o  = 1'b1;
                    // A zero operand runs a single no-op step on cleared registers.
                    cnt_d   = zero_i ? LAST : '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                step_o = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                dest_valid_o = 1'b1;
                if (dest_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/booth_mul_vr.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes, signed/unsigned mode.
// Optional zero-operand fast path under BOOTH_ZERO_BYPASS_EN.
module booth_mul_vr
    import booth_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = booth_cnt_w(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               src_valid,
    output logic               src_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               signed_mode,
    output logic               dest_valid,
    input  logic               dest_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    booth_state_e   state;
    booth_op_e      op;
    logic           load, step, zero;
    logic [WIDTH:0] a_q, a_d, q_q, q_d, m_q, m_d;
    logic           qm1_q, qm1_d;
    logic [WIDTH:0] m_ext, q_ext, m_load, q_load, sum;

    assign m_ext = {signed_mode & multiplicand[WIDTH-1], multiplicand};
    assign q_ext = {signed_mode & multiplier[WIDTH-1], multiplier};

`ifdef BOOTH_ZERO_BYPASS_EN
    assign zero   = (multiplicand == '0) || (multiplier == '0);
    assign m_load = zero ? '0 : m_ext;
    assign q_load = zero ? '0 : q_ext;
`else
    assign zero   = 1'b0;
    assign m_load = m_ext;
    assign q_load = q_ext;
`endif

    booth_mul_vr_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .src_valid_i  (src_valid),
        .dest_ready_i (dest_ready),
        .zero_i       (zero),
        .src_ready_o  (src_ready),
        .dest_valid_o (dest_valid),
        .load_o       (load),
        .step_o       (step),
        .state_o      (state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            q_q   <= '0;
            m_q   <= '0;
            qm1_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            m_q   <= m_d;
            qm1_q <= qm1_d;
        end
    end

    always_comb begin
        op    = booth_decode(q_q[0], qm1_q);
        a_d   = a_q;
        q_d   = q_q;
        m_d   = m_q;
        qm1_d = qm1_q;
        case (op)
            OP_ADD:  sum = a_q + m_q;
            OP_SUB:  sum = a_q - m_q;
            default: sum = a_q;
        endcase
        if (load) begin
            a_d   = '0;
            q_d   = q_load;
            m_d   = m_load;
            qm1_d = 1'b0;
        end else if (step) begin
            // Arithmetic right shift of {A, Q, Q-1} after the add/subtract.
            a_d   = {sum[WIDTH], sum[WIDTH:1]};
            q_d   = {sum[0], q_q[WIDTH:1]};
            qm1_d = q_q[0];
        end
    end

    assign product = dest_valid ? {a_q[WIDTH-2:0], q_q} : '0;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_booth_mul_vr.sv
// Directed self-checking bench for booth_mul_vr at WIDTH=8.
module tb_booth_mul_vr;

    localparam int W = 8;
`ifdef BOOTH_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = W + 1;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           src_valid;
    logic           src_ready;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           signed_mode;
    logic           dest_valid;
    logic           dest_ready;
    logic [2*W-1:0] product;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [2*W-1:0] exp_q[$];

    booth_mul_vr #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .signed_mode  (signed_mode),
        .dest_valid   (dest_valid),
        .dest_ready   (dest_ready),
        .product      (product),
        .busy         (busy)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one transaction and measures edges from accept to dest_valid.
    task automatic start_and_wait(input logic [W-1:0] m, input logic [W-1:0] q, input logic sm,
                                  input logic [2*W-1:0] exp_p, input int exp_lat, input string tag);
        int t;
        int lat;
        multiplicand = m;
        multiplier   = q;
        signed_mode  = sm;
        src_valid    = 1'b1;
        t = 0;
        while (!src_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        @(posedge clk); #1;
        src_valid = 1'b0;
        lat = 0;
        while (!dest_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_prod"}, 64'(product), 64'(exp_p));
    endtask

    task automatic txn(input logic [W-1:0] m, input logic [W-1:0] q, input logic sm,
                       input logic [2*W-1:0] exp_p, input int exp_lat, input string tag);
        start_and_wait(m, q, sm, exp_p, exp_lat, tag);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(dest_valid), 64'd0);
        check({tag, "_ready"}, 64'(src_ready), 64'd1);
    endtask

    // scoreboard for back-to-back results
    always @(negedge clk) begin
        if (mon_en && dest_valid && dest_ready) begin
            if (exp_q.size() == 0) check("b2b_unexpected", 64'd1, 64'd0);
            else check("b2b_prod", 64'(product), 64'(exp_q.pop_front()));
        end
    end

    logic [W-1:0]   bm[4] = '{8'h03, 8'hC8, 8'hFF, 8'h10};
    logic [W-1:0]   bq[4] = '{8'hFC, 8'h03, 8'hFF, 8'h10};
    logic           bs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2*W-1:0] be[4] = '{16'hFFF4, 16'h0258, 16'h0001, 16'h0100};

    initial begin
        int acc_cyc;
        int prev_cyc;
        int t;
        bit seen;
        rst = 1'b1; src_valid = 1'b0; multiplicand = '0; multiplier = '0;
        signed_mode = 1'b0; dest_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_src_ready", 64'(src_ready), 64'd1);
        check("rst_dest_valid", 64'(dest_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_product", 64'(product), 64'd0);

        txn(8'hFD, 8'h05, 1'b1, 16'hFFF1, 9, "s_m3x5");
        txn(8'hFD, 8'h05, 1'b0, 16'h04F1, 9, "u_253x5");
        txn(8'hFF, 8'hFF, 1'b0, 16'hFE01, 9, "u_max");
        txn(8'h80, 8'h80, 1'b1, 16'h4000, 9, "s_minmin");
        txn(8'h80, 8'h7F, 1'b1, 16'hC080, 9, "s_minmax");
        txn(8'h7F, 8'h7F, 1'b1, 16'h3F01, 9, "s_maxmax");
        txn(8'h00, 8'hC8, 1'b0, 16'h0000, ZLAT, "z_0x200");
        txn(8'h05, 8'h00, 1'b1, 16'h0000, ZLAT, "z_5x0");

        // backpressure
        dest_ready = 1'b0;
        start_and_wait(8'h12, 8'h34, 1'b0, 16'h03A8, 9, "bp");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp_hold_prod", 64'(product), 64'h03A8);
            check("bp_hold_valid", 64'(dest_valid), 64'd1);
            check("bp_hold_src_ready", 64'(src_ready), 64'd0);
            check("bp_hold_busy", 64'(busy), 64'd1);
        end
        dest_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 64'(dest_valid), 64'd0);
        check("bp_release_ready", 64'(src_ready), 64'd1);

        // back-to-back with src_valid held high
        mon_en = 1'b1;
        prev_cyc = 0;
        src_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            multiplicand = bm[i]; multiplier = bq[i]; signed_mode = bs[i];
            t = 0;
            while (!src_ready && t < 50) begin
                @(posedge clk); #1; t++;
            end
            @(posedge clk);
            acc_cyc = cyc;
            exp_q.push_back(be[i]);
            #1;
            if (i > 0) check("b2b_interval", 64'(acc_cyc - prev_cyc), 64'(W + 3));
            prev_cyc = acc_cyc;
        end
        src_valid = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(posedge clk); #1; t++;
        end
        check("b2b_drained", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;

        // reset in the middle of BUSY
        multiplicand = 8'h55; multiplier = 8'h33; signed_mode = 1'b0; src_valid = 1'b1;
        @(posedge clk); #1;
        src_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_src_ready", 64'(src_ready), 64'd1);
        check("mid_rst_dest_valid", 64'(dest_valid), 64'd0);
        check("mid_rst_product", 64'(product), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (dest_valid) seen = 1'b1;
        end
        check("mid_rst_no_valid", 64'(seen), 64'd0);
        txn(8'h07, 8'h06, 1'b0, 16'h002A, 9, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
